dff_en: RTL and testbench
=========================

Name: dff_en

Overview:
- Clock-enabled D flip-flop register with complementary outputs; the basic state element for control and datapath registers.
- Captures D on the rising clock edge only when the enable is high; otherwise holds.
- QNOT is always the bitwise complement of Q.
- Built as WIDTH independent one-bit cells sharing clock, enable and reset.

Parameters:
- WIDTH, 1, data width in bits of D, Q and QNOT (legal range 1..64).
- RST_VAL, all zeros ({WIDTH{1'b0}}), value loaded into Q while reset is asserted.

Ports:
- clk  input  1  system clock; all state changes on its rising edge, except reset.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- D  input  WIDTH  data to capture.
- e  input  1  clock enable; 1 = load D, 0 = hold.
- Q  output  WIDTH  registered data.
- QNOT  output  WIDTH  bitwise complement of Q.

Behaviour:
- Reset:
  - rst falling to 0 forces Q = RST_VAL and QNOT = ~RST_VAL immediately, independent of clk.
  - Reset holds these values for as long as rst = 0; D and e are ignored during that time.
- Reset release:
  - Deassertion (rst 0 -> 1) takes effect with no internal synchronizer; the integrator guarantees release is synchronous to clk.
  - The first rising edge with rst = 1 is a normal capture edge.
- Capture: at each rising clk edge with rst = 1:
  - e = 1: Q <= D.
  - e = 0: Q keeps its previous value.
  - Latency is 1 cycle from D/e at the sampling edge to Q.
- QNOT:
  - Purely combinational, QNOT = ~Q, in every state including reset.
  - Never simultaneously equal to Q.
- Power-up: before the first reset, Q is unknown. The system must apply reset before use; no implicit initial value.
- Simultaneous events: reset asserted on the same edge as a clock edge with e = 1 means reset wins and Q = RST_VAL.
- Reset mid-operation: state is lost and Q returns to RST_VAL. After release, the register behaves as if freshly reset.
- Unknown inputs: the implementation must not mask X on D when e = 1. X on e is a verification error, flagged by an assertion in simulation.
- Implementation constraints:
  - No latches.
  - One always block per bit cell, sensitive to posedge clk and negedge rst.
  - Enable realized as a hold mux, not clock gating.

Decomposition:
- Shared package: no typedefs or constants needed; WIDTH and RST_VAL stay as local parameters.
- Sub-module dff_en_cell: one-bit cell with ports clk, rst, d, e, rst_val, q, qn.
- The top level instantiates WIDTH cells in a generate loop, feeding each cell its bit of RST_VAL.
- Simulation-only assertions in the top level:
  - QNOT == ~Q.
  - e not X when rst = 1.

Test Plan:
- Reset: WIDTH=1, clk period 10 ns, D=0, e=0, drive rst=0 for 5 ns mid-cycle -> Q=0 and QNOT=1 immediately, before the next clk edge.
- Hold with enable low: rst=1, e=0, D=1 for 10 cycles -> Q stays 0 and QNOT stays 1 throughout.
- Load: rst=1, set D=1, e=1 before an edge -> Q=1 and QNOT=0 after that rising edge; stable for 15 cycles while D=1.
- Disable and change D: e=0, D=0 after Q=1 -> Q remains 1 on all following edges. Then e=1 -> Q=0 one edge later.
- Async reset mid-operation: Q=1 and e=1, pulse rst=0 between edges -> Q drops to 0 without a clock edge. After release, next edge with D=1, e=1 -> Q=1.
- Width/reset value: WIDTH=8, RST_VAL=8'hA5:
  - reset -> Q=8'hA5, QNOT=8'h5A.
  - D=8'h3C, e=1 -> Q=8'h3C, QNOT=8'hC3 after one edge.

Source files
------------

// File: rtl/dff_en_pkg.sv
// Shared definitions for the clock-enabled register family.
// Only the legal width bound lives here; WIDTH and RST_VAL stay as parameters.
package dff_en_pkg;

  localparam int DFF_EN_MAX_WIDTH = 64;

endpackage

// File: rtl/dff_en_cell.sv
// One-bit clock-enabled flip-flop with async active-low reset and complementary output.
// The enable is a hold mux in front of the flop; the clock is never gated.
module dff_en_cell (
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic e,
  input  logic rst_val,
  output logic q,
  output logic qn
);

  logic q_q;
  logic q_d;

  // A ternary passes an X on d straight through when e = 1.
  always_comb begin
    q_d = e ? d : q_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= rst_val;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign qn = ~q_q;

endmodule

// File: rtl/dff_en.sv
// WIDTH-bit clock-enabled register with complementary outputs, built from
// independent one-bit cells that share clock, enable and reset.
module dff_en
  import dff_en_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  input  logic             e,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QNOT
);

  if (WIDTH < 1 || WIDTH > DFF_EN_MAX_WIDTH) begin : g_bad_width
    $error("dff_en: WIDTH %0d outside 1..%0d", WIDTH, DFF_EN_MAX_WIDTH);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    dff_en_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .d       (D[i]),
      .e       (e),
      .rst_val (RST_VAL[i]),
      .q       (Q[i]),
      .qn      (QNOT[i])
    );
  end

  // Simulation-only sanity checks; synthesis ignores assertions.
  always_comb begin
    assert (QNOT === ~Q)
      else $error("dff_en: QNOT is not the complement of Q");
  end

  assert property (@(posedge clk) disable iff (!rst) !$isunknown(e))
    else $error("dff_en: enable is X/Z while out of reset");

endmodule

// File: tb/tb_dff_en.sv
// Directed self-checking bench for dff_en: a 1-bit default instance and an
// 8-bit instance with a non-zero reset value.
module tb_dff_en;

  logic       clk;
  logic       rst1, rst8;
  logic       d1, e1, e8;
  logic       q1, qn1;
  logic [7:0] d8, q8, qn8;

  int checks = 0;
  int errors = 0;

  dff_en u_dut1 (
    .clk  (clk),
    .rst  (rst1),
    .D    (d1),
    .e    (e1),
    .Q    (q1),
    .QNOT (qn1)
  );

  dff_en #(.WIDTH(8), .RST_VAL(8'hA5)) u_dut8 (
    .clk  (clk),
    .rst  (rst8),
    .D    (d8),
    .e    (e8),
    .Q    (q8),
    .QNOT (qn8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(posedge clk);
    #2;
    rst1 = 1'b0;
    rst8 = 1'b0;
    #1;
    checks++;
    if (q1 !== 1'b0 || qn1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_1b: Q=%b QNOT=%b, required Q=0 QNOT=1", q1, qn1);
    end
    checks++;
    if (q8 !== 8'hA5 || qn8 !== 8'h5A) begin
      errors++;
      $display("FAIL reset_8b: Q=%h QNOT=%h, required Q=a5 QNOT=5a", q8, qn8);
    end
    #4;
    rst1 = 1'b1;
    rst8 = 1'b1;
  endtask

  task automatic test_hold();
    @(negedge clk);
    d1 = 1'b1;
    e1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (q1 !== 1'b0 || qn1 !== 1'b1) begin
        errors++;
        $display("FAIL hold_cycle%0d: Q=%b QNOT=%b, required Q=0 QNOT=1", i, q1, qn1);
      end
    end
  endtask

  task automatic test_load();
    @(negedge clk);
    d1 = 1'b1;
    e1 = 1'b1;
    #1;
    checks++;
    if (q1 !== 1'b0) begin
      errors++;
      $display("FAIL load_before_edge: Q=%b, required 0", q1);
    end
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (q1 !== 1'b1 || qn1 !== 1'b0) begin
        errors++;
        $display("FAIL load_cycle%0d: Q=%b QNOT=%b, required Q=1 QNOT=0", i, q1, qn1);
      end
    end
  endtask

  task automatic test_disable();
    @(negedge clk);
    e1 = 1'b0;
    d1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (q1 !== 1'b1 || qn1 !== 1'b0) begin
        errors++;
        $display("FAIL disable_hold%0d: Q=%b QNOT=%b, required Q=1 QNOT=0", i, q1, qn1);
      end
    end
    @(negedge clk);
    e1 = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (q1 !== 1'b0 || qn1 !== 1'b1) begin
      errors++;
      $display("FAIL reenable_load0: Q=%b QNOT=%b, required Q=0 QNOT=1", q1, qn1);
    end
  endtask

  task automatic test_async_mid();
    @(negedge clk);
    d1 = 1'b1;
    e1 = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (q1 !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: Q=%b, required 1", q1);
    end
    #2;
    rst1 = 1'b0;
    #1;
    checks++;
    if (q1 !== 1'b0 || qn1 !== 1'b1) begin
      errors++;
      $display("FAIL async_drop: Q=%b QNOT=%b, required Q=0 QNOT=1", q1, qn1);
    end
    // Reset held across a capture edge with e=1, D=1: reset must win.
    @(posedge clk);
    #1;
    checks++;
    if (q1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_wins_edge: Q=%b, required 0", q1);
    end
    @(negedge clk);
    rst1 = 1'b1;
    #1;
    checks++;
    if (q1 !== 1'b0) begin
      errors++;
      $display("FAIL release_no_edge: Q=%b, required 0", q1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (q1 !== 1'b1 || qn1 !== 1'b0) begin
      errors++;
      $display("FAIL after_release_load: Q=%b QNOT=%b, required Q=1 QNOT=0", q1, qn1);
    end
  endtask

  task automatic test_width8();
    // e8 has stayed low since reset release, so the reset value must persist.
    @(posedge clk);
    #1;
    checks++;
    if (q8 !== 8'hA5 || qn8 !== 8'h5A) begin
      errors++;
      $display("FAIL w8_hold_rstval: Q=%h QNOT=%h, required Q=a5 QNOT=5a", q8, qn8);
    end
    @(negedge clk);
    d8 = 8'h3C;
    e8 = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (q8 !== 8'h3C || qn8 !== 8'hC3) begin
      errors++;
      $display("FAIL w8_load: Q=%h QNOT=%h, required Q=3c QNOT=c3", q8, qn8);
    end
    @(negedge clk);
    d8 = 8'hF0;
    e8 = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (q8 !== 8'h3C) begin
      errors++;
      $display("FAIL w8_hold: Q=%h, required 3c", q8);
    end
    @(negedge clk);
    e8 = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (q8 !== 8'hF0 || qn8 !== 8'h0F) begin
      errors++;
      $display("FAIL w8_load2: Q=%h QNOT=%h, required Q=f0 QNOT=0f", q8, qn8);
    end
    #2;
    rst8 = 1'b0;
    #1;
    checks++;
    if (q8 !== 8'hA5 || qn8 !== 8'h5A) begin
      errors++;
      $display("FAIL w8_async_reset: Q=%h QNOT=%h, required Q=a5 QNOT=5a", q8, qn8);
    end
    @(negedge clk);
    rst8 = 1'b1;
  endtask

  initial begin
    rst1 = 1'b1;
    rst8 = 1'b1;
    d1   = 1'b0;
    e1   = 1'b0;
    d8   = 8'h00;
    e8   = 1'b0;
    test_reset();
    test_hold();
    test_load();
    test_disable();
    test_async_mid();
    test_width8();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
